// File: rtl/ad_bridge_rx_if.sv
// Sample bus from the analog solver: one quantised node voltage code plus
// a strobe marking the cycle on which a new sample is posted.
interface ad_bridge_rx_if #(
    parameter int CODE_W = 12
);
    logic [CODE_W-1:0] ana_code;
    logic              ana_valid;

    modport master (output ana_code, output ana_valid);
    modport slave  (input  ana_code, input  ana_valid);
endinterface

// File: rtl/ad_bridge_rx.sv
// Analog-to-digital end of the cosimulation bridge. Turns the solver's
// sampled node voltage into a clean logic level using hysteresis thresholds
// and a consecutive-sample deglitch filter. Reports timestamped edges, an
// unknown-level flag, a saturating count of aborted transitions and a
// stale-input flag.
module ad_bridge_rx #(
    parameter int CODE_W    = 12,
    parameter int VIL       = 1229,
    parameter int VIH       = 2867,
    parameter int FILT      = 3,
    parameter int STALE_CYC = 1000,
    parameter int TS_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ad_bridge_rx_if.slave     ana,
    output logic              dig_out,
    output logic              dig_x,
    output logic              edge_rise,
    output logic              edge_fall,
    output logic [TS_W-1:0]   edge_time,
    output logic [7:0]        glitch_cnt,
    output logic              stale
);

    localparam logic [CODE_W-1:0] VIL_C   = CODE_W'(VIL);
    localparam logic [CODE_W-1:0] VIH_C   = CODE_W'(VIH);
    localparam logic [3:0]        FILT_C  = 4'(FILT);
    localparam int                SC_W    = $clog2(STALE_CYC + 1);
    localparam logic [SC_W-1:0]   STALE_C = SC_W'(STALE_CYC);
    localparam bit                FAST    = (FILT == 1);

    if (VIL >= VIH) begin : g_bad_thresholds
        $error("ad_bridge_rx: VIL (%0d) must be below VIH (%0d)", VIL, VIH);
    end
    if (FILT < 1 || FILT > 15) begin : g_bad_filt
        $error("ad_bridge_rx: FILT (%0d) must be in 1..15", FILT);
    end

    typedef enum logic [2:0] {
        ST_X, ST_LOW, ST_RISE_P, ST_HIGH, ST_FALL_P
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            from_x, from_x_nxt;   // pending transition began in X
    logic            enter_high, enter_low, edge_ok, abort;
    logic [TS_W-1:0] ts;
    logic [SC_W-1:0] stale_cnt;
    logic            is_h, is_l;
    logic [3:0]      cnt_inc;

    assign is_h    = ana.ana_code >= VIH_C;
    assign is_l    = ana.ana_code <= VIL_C;
    assign cnt_inc = cnt + 4'd1;
    assign stale   = (stale_cnt == STALE_C);

    // Filter state register; reset drops any pending transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_X;
            cnt    <= 4'd0;
            from_x <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            from_x <= from_x_nxt;
        end
    end

    // Next state: only valid samples move the filter; a non-qualifying
    // sample while pending falls back to the last stable state
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        from_x_nxt = from_x;
        enter_high = 1'b0;
        enter_low  = 1'b0;
        edge_ok    = 1'b0;
        abort      = 1'b0;
        if (ana.ana_valid) begin
            unique case (state)
                ST_X, ST_LOW: begin
                    if (is_h) begin
                        if (FAST) begin
                            state_nxt  = ST_HIGH;
                            enter_high = 1'b1;
                            edge_ok    = (state == ST_LOW);
                        end else begin
                            state_nxt  = ST_RISE_P;
                            cnt_nxt    = 4'd1;
                            from_x_nxt = (state == ST_X);
                        end
                    end else if (is_l && state == ST_X) begin
                        if (FAST) begin
                            state_nxt = ST_LOW;
                            enter_low = 1'b1;
                        end else begin
                            state_nxt  = ST_FALL_P;
                            cnt_nxt    = 4'd1;
                            from_x_nxt = 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (is_l) begin
                        if (FAST) begin
                            state_nxt = ST_LOW;
                            enter_low = 1'b1;
                            edge_ok   = 1'b1;
                        end else begin
                            state_nxt  = ST_FALL_P;
                            cnt_nxt    = 4'd1;
                            from_x_nxt = 1'b0;
                        end
                    end
                end
                ST_RISE_P: begin
                    if (is_h) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == FILT_C) begin
                            state_nxt  = ST_HIGH;
                            enter_high = 1'b1;
                            edge_ok    = !from_x;
                            cnt_nxt    = 4'd0;
                        end
                    end else begin
                        abort     = 1'b1;
                        state_nxt = from_x ? ST_X : ST_LOW;
                        cnt_nxt   = 4'd0;
                    end
                end
                ST_FALL_P: begin
                    if (is_l) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == FILT_C) begin
                            state_nxt = ST_LOW;
                            enter_low = 1'b1;
                            edge_ok   = !from_x;
                            cnt_nxt   = 4'd0;
                        end
                    end else begin
                        abort     = 1'b1;
                        state_nxt = from_x ? ST_X : ST_HIGH;
                        cnt_nxt   = 4'd0;
                    end
                end
                default: state_nxt = ST_X;
            endcase
        end
    end

    // Registered level, edge pulses, edge timestamp and glitch counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_out    <= 1'b0;
            dig_x      <= 1'b1;
            edge_rise  <= 1'b0;
            edge_fall  <= 1'b0;
            edge_time  <= '0;
            glitch_cnt <= 8'd0;
            ts         <= '0;
        end else begin
            ts        <= ts + TS_W'(1);
            edge_rise <= enter_high && edge_ok;
            edge_fall <= enter_low && edge_ok;
            if (enter_high || enter_low) begin
                dig_out <= enter_high;
                dig_x   <= 1'b0;
            end
            if ((enter_high || enter_low) && edge_ok)
                edge_time <= ts;
            if (abort && glitch_cnt != 8'hFF)
                glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

    // Cycles since the last sample, saturating at the stale limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stale_cnt <= '0;
        else if (ana.ana_valid)
            stale_cnt <= '0;
        else if (stale_cnt != STALE_C)
            stale_cnt <= stale_cnt + SC_W'(1);
    end

endmodule

// File: tb/tb_ad_bridge_rx.sv
// Directed bench for ad_bridge_rx: a default instance (FILT=3, 32-bit
// timestamp) and a second instance with a 4-bit timestamp for wrap checks.
module tb_ad_bridge_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] tb_cyc;
    logic [31:0] last_ts;

    ad_bridge_rx_if #(.CODE_W(12)) bus1();
    ad_bridge_rx_if #(.CODE_W(12)) bus2();

    logic        dig_out, dig_x, edge_rise, edge_fall, stale;
    logic [31:0] edge_time;
    logic [7:0]  glitch_cnt;
    logic        dig_out2, dig_x2, edge_rise2, edge_fall2, stale2;
    logic [3:0]  edge_time2;
    logic [7:0]  glitch_cnt2;

    always #5 clk = ~clk;

    // Reference cycle count: value of the DUT timestamp in the current cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    ad_bridge_rx #(.CODE_W(12), .VIL(1229), .VIH(2867), .FILT(3),
                   .STALE_CYC(1000), .TS_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ana(bus1.slave),
        .dig_out(dig_out), .dig_x(dig_x), .edge_rise(edge_rise),
        .edge_fall(edge_fall), .edge_time(edge_time),
        .glitch_cnt(glitch_cnt), .stale(stale));

    ad_bridge_rx #(.CODE_W(12), .VIL(1229), .VIH(2867), .FILT(3),
                   .STALE_CYC(1000), .TS_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .ana(bus2.slave),
        .dig_out(dig_out2), .dig_x(dig_x2), .edge_rise(edge_rise2),
        .edge_fall(edge_fall2), .edge_time(edge_time2),
        .glitch_cnt(glitch_cnt2), .stale(stale2));

    task automatic sample1(input logic [11:0] code);
        bus1.ana_code  = code;
        bus1.ana_valid = 1'b1;
        last_ts        = tb_cyc;
        @(posedge clk); #1;
        bus1.ana_valid = 1'b0;
    endtask

    task automatic sample2(input logic [11:0] code);
        bus2.ana_code  = code;
        bus2.ana_valid = 1'b1;
        last_ts        = tb_cyc;
        @(posedge clk); #1;
        bus2.ana_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dig_out !== 1'b0) begin n_err++; $display("FAIL reset_dig_out: got %0b want 0", dig_out); end
        n_cmp++; if (dig_x !== 1'b1) begin n_err++; $display("FAIL reset_dig_x: got %0b want 1", dig_x); end
        n_cmp++; if (edge_rise !== 1'b0 || edge_fall !== 1'b0) begin n_err++; $display("FAIL reset_edges: got %0b%0b want 00", edge_rise, edge_fall); end
        n_cmp++; if (edge_time !== 32'd0) begin n_err++; $display("FAIL reset_edge_time: got %0d want 0", edge_time); end
        n_cmp++; if (glitch_cnt !== 8'd0 || stale !== 1'b0) begin n_err++; $display("FAIL reset_glitch_stale: got %0d/%0b want 0/0", glitch_cnt, stale); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_level;
        sample1(12'd3000);
        sample1(12'd3000);
        n_cmp++; if (dig_x !== 1'b1) begin n_err++; $display("FAIL first_x_early: got %0b want 1", dig_x); end
        sample1(12'd3000);
        n_cmp++; if (dig_x !== 1'b0 || dig_out !== 1'b1) begin n_err++; $display("FAIL first_level: got x=%0b out=%0b want x=0 out=1", dig_x, dig_out); end
        n_cmp++; if (edge_rise !== 1'b0 || edge_time !== 32'd0) begin n_err++; $display("FAIL first_no_edge: got rise=%0b time=%0d want 0/0", edge_rise, edge_time); end
    endtask

    task automatic test_fall;
        logic [31:0] exp_t;
        sample1(12'd1000);
        sample1(12'd1000);
        n_cmp++; if (dig_out !== 1'b1) begin n_err++; $display("FAIL fall_early: got %0b want 1", dig_out); end
        sample1(12'd1000);
        exp_t = last_ts;
        n_cmp++; if (dig_out !== 1'b0 || edge_fall !== 1'b1) begin n_err++; $display("FAIL fall_edge: got out=%0b fall=%0b want 0/1", dig_out, edge_fall); end
        n_cmp++; if (edge_time !== exp_t) begin n_err++; $display("FAIL fall_time: got %0d want %0d", edge_time, exp_t); end
        @(posedge clk); #1;
        n_cmp++; if (edge_fall !== 1'b0) begin n_err++; $display("FAIL fall_pulse_width: got %0b want 0", edge_fall); end
    endtask

    task automatic test_glitch;
        logic [31:0] exp_t;
        sample1(12'd3000);
        sample1(12'd3000);
        sample1(12'd2000);
        n_cmp++; if (glitch_cnt !== 8'd1 || dig_out !== 1'b0) begin n_err++; $display("FAIL glitch_abort: got cnt=%0d out=%0b want 1/0", glitch_cnt, dig_out); end
        sample1(12'd3000);
        sample1(12'd3000);
        n_cmp++; if (edge_rise !== 1'b0 || dig_out !== 1'b0) begin n_err++; $display("FAIL glitch_restart: got rise=%0b out=%0b want 0/0", edge_rise, dig_out); end
        sample1(12'd3000);
        exp_t = last_ts;
        n_cmp++; if (edge_rise !== 1'b1 || dig_out !== 1'b1) begin n_err++; $display("FAIL glitch_rise: got rise=%0b out=%0b want 1/1", edge_rise, dig_out); end
        n_cmp++; if (edge_time !== exp_t) begin n_err++; $display("FAIL glitch_rise_time: got %0d want %0d", edge_time, exp_t); end
    endtask

    task automatic test_midband;
        logic seen;
        repeat (3) sample1(12'd1000);
        n_cmp++; if (dig_out !== 1'b0 || edge_fall !== 1'b1) begin n_err++; $display("FAIL mid_setup_fall: got out=%0b fall=%0b want 0/1", dig_out, edge_fall); end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            sample1(12'd2000);
            if (dig_out !== 1'b0 || edge_rise !== 1'b0 || edge_fall !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0 || glitch_cnt !== 8'd1) begin n_err++; $display("FAIL mid_hold: got moved=%0b glitch=%0d want 0/1", seen, glitch_cnt); end
        repeat (3) sample1(12'd2867);
        n_cmp++; if (edge_rise !== 1'b1 || dig_out !== 1'b1) begin n_err++; $display("FAIL vih_exact: got rise=%0b out=%0b want 1/1", edge_rise, dig_out); end
        repeat (3) sample1(12'd1230);
        n_cmp++; if (dig_out !== 1'b1 || glitch_cnt !== 8'd1) begin n_err++; $display("FAIL vil_plus1: got out=%0b glitch=%0d want 1/1", dig_out, glitch_cnt); end
        repeat (3) sample1(12'd1229);
        n_cmp++; if (edge_fall !== 1'b1 || dig_out !== 1'b0) begin n_err++; $display("FAIL vil_exact: got fall=%0b out=%0b want 1/0", edge_fall, dig_out); end
    endtask

    task automatic test_stale;
        repeat (999) @(posedge clk);
        #1;
        n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL stale_early: got %0b want 0", stale); end
        @(posedge clk); #1;
        n_cmp++; if (stale !== 1'b1 || dig_out !== 1'b0) begin n_err++; $display("FAIL stale_set: got stale=%0b out=%0b want 1/0", stale, dig_out); end
        sample1(12'd3000);
        n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL stale_clear: got %0b want 0", stale); end
    endtask

    task automatic test_reset_mid;
        sample1(12'd3000);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (dig_x !== 1'b1 || dig_out !== 1'b0) begin n_err++; $display("FAIL rstmid_level: got x=%0b out=%0b want 1/0", dig_x, dig_out); end
        n_cmp++; if (glitch_cnt !== 8'd0 || edge_time !== 32'd0) begin n_err++; $display("FAIL rstmid_counters: got glitch=%0d time=%0d want 0/0", glitch_cnt, edge_time); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sample1(12'd3000);
        sample1(12'd3000);
        n_cmp++; if (dig_x !== 1'b1) begin n_err++; $display("FAIL rstmid_discard: got x=%0b want 1", dig_x); end
        sample1(12'd3000);
        n_cmp++; if (dig_x !== 1'b0 || dig_out !== 1'b1 || edge_rise !== 1'b0) begin n_err++; $display("FAIL rstmid_relock: got x=%0b out=%0b rise=%0b want 0/1/0", dig_x, dig_out, edge_rise); end
    endtask

    task automatic test_glitch_sat;
        repeat (3) sample1(12'd1000);
        for (int i = 0; i < 300; i++) begin
            sample1(12'd3000);
            sample1(12'd2000);
            if (i == 254) begin
                n_cmp++; if (glitch_cnt !== 8'd255) begin n_err++; $display("FAIL glitch_255: got %0d want 255", glitch_cnt); end
            end
        end
        n_cmp++; if (glitch_cnt !== 8'd255 || dig_out !== 1'b0) begin n_err++; $display("FAIL glitch_sat: got cnt=%0d out=%0b want 255/0", glitch_cnt, dig_out); end
    endtask

    task automatic test_ts_wrap;
        logic [3:0] exp_t;
        repeat (3) sample2(12'd3000);
        n_cmp++; if (dig_out2 !== 1'b1 || edge_time2 !== 4'd0) begin n_err++; $display("FAIL wrap_setup: got out=%0b time=%0d want 1/0", dig_out2, edge_time2); end
        repeat (3) sample2(12'd1000);
        exp_t = last_ts[3:0];
        n_cmp++; if (edge_fall2 !== 1'b1 || edge_time2 !== exp_t) begin n_err++; $display("FAIL wrap_time: got fall=%0b time=%0d want 1/%0d", edge_fall2, edge_time2, exp_t); end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus1.ana_code  = 12'd0;
        bus1.ana_valid = 1'b0;
        bus2.ana_code  = 12'd0;
        bus2.ana_valid = 1'b0;
        last_ts        = 32'd0;
        test_reset;
        test_first_level;
        test_fall;
        test_glitch;
        test_midband;
        test_stale;
        test_reset_mid;
        test_glitch_sat;
        test_ts_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ad_bridge_rx.md
Name: ad_bridge_rx

Overview:
- Analog-to-digital end of the cosimulation bridge; the digital driver path (inverter model with signal sync-out) is the digital-to-analog end.
- Receives the quantised node voltage that the analog solver posts at each sync point.
- Converts it to a clean logic level using hysteresis and a consecutive-sample deglitch filter.
- Reports rise/fall edge events with a cycle timestamp, an unknown (X) flag and a stale-input flag to the digital models.

Parameters:
- CODE_W, 12, width of analog sample code (0 = vss, 2^CODE_W-1 = vdd)
- VIL, 1229, low threshold code (~30% of 3.0 V); sample <= VIL is logic 0
- VIH, 2867, high threshold code (~70% of 3.0 V); sample >= VIH is logic 1; VIL < VIH is required
- FILT, 3, consecutive qualifying samples needed to change level (1..15)
- STALE_CYC, 1000, clk cycles without ana_valid before stale asserts
- TS_W, 32, timestamp counter width

Ports:
- clk  input  1  bridge clock
- rst_n  input  1  asynchronous active-low reset
- ana_code  input  CODE_W  sampled analog voltage code
- ana_valid  input  1  one-cycle strobe: ana_code holds a new sample
- dig_out  output  1  filtered logic level
- dig_x  output  1  level unknown (no qualified level since reset)
- edge_rise  output  1  one-cycle pulse on a 0->1 transition
- edge_fall  output  1  one-cycle pulse on a 1->0 transition
- edge_time  output  TS_W  timestamp counter value latched at the last edge
- glitch_cnt  output  8  count of aborted transitions, saturating at 255
- stale  output  1  no sample received for STALE_CYC cycles

Behaviour:
- Reset (async, rst_n=0):
  - state=X; dig_out=0; dig_x=1.
  - edge_rise=0, edge_fall=0, edge_time=0, glitch_cnt=0, stale=0.
  - Timestamp, filter and stale counters cleared.
  - Reset asserted mid-transition discards the pending count.
- Timestamp: free-running, +1 per clk, wraps modulo 2^TS_W.
- Sample classification applies only on cycles with ana_valid=1:
  - H if code >= VIH.
  - L if code <= VIL.
  - M (mid band) otherwise.
- Cycles with ana_valid=0 leave the state and the filter count unchanged.
- States: X, LOW, RISE_P, HIGH, FALL_P. The filter count cnt is 4 bits.
- X:
  - First H: go to RISE_P with cnt=1; first L: go to FALL_P with cnt=1.
  - M: stay in X.
  - FILT=1 goes directly to HIGH or LOW.
- LOW:
  - H: go to RISE_P with cnt=1, or directly to HIGH if FILT=1.
  - L or M: stay in LOW (hysteresis).
- RISE_P:
  - H: cnt+1; when cnt reaches FILT, go to HIGH.
  - L or M: abort and return to the prior stable state (LOW, or X if entered from X); glitch_cnt+1.
- HIGH and FALL_P mirror LOW and RISE_P, with L as the qualifying sample.
- Output timing (the qualifying sample cycle is N):
  - Entering HIGH/LOW sets dig_out and clears dig_x, registered at the next edge (latency 1 clk from the qualifying ana_valid).
  - X->HIGH and X->LOW produce no edge pulse and no timestamp update.
  - LOW->HIGH: edge_rise=1 for exactly one cycle (cycle N+1); edge_time captures the timestamp value at cycle N.
  - HIGH->LOW: same timing with edge_fall.
- Stale:
  - Counter clears on every ana_valid and otherwise counts, saturating at STALE_CYC.
  - stale=1 while the count equals STALE_CYC; cleared in the cycle after the next ana_valid.
  - Stale does not change the logic state.
- Boundaries:
  - code exactly VIH counts as H; code exactly VIL counts as L.
  - glitch_cnt holds at 255.
  - ana_valid held high for consecutive cycles means one sample per cycle.
  - Parameter VIL >= VIH is illegal; elaboration must fail with $error.

Test Plan:
- Reset, then ana_valid samples 3000,3000,3000 (FILT=3) -> dig_x falls and dig_out=1 one cycle after the 3rd sample; edge_rise stays 0.
- From HIGH, samples 1000,1000,1000 -> dig_out=0 at cycle N+1; edge_fall pulses exactly one cycle; edge_time = timestamp at the 3rd sample.
- From LOW, samples 3000,3000,2000,3000 -> no rise; glitch_cnt=1; state LOW/RISE_P with cnt=1 after the final sample; then 2 more H -> edge_rise.
- From LOW, 50 samples of 2000 (mid band) -> dig_out stays 0, no edges, glitch_cnt unchanged; boundary samples 2867 x3 -> rise, 1229 x3 -> fall.
- Hold ana_valid=0 for 1000 cycles -> stale=1 at cycle 1000; one sample -> stale=0 next cycle; assert rst_n=0 during RISE_P -> all outputs at reset values immediately, dig_x=1.
- Force 300 aborted rises -> glitch_cnt saturates at 255; timestamp wrap with TS_W=4 -> edge_time reflects the wrapped value.
